load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Load-side counterpart of the store byte-enable path: multi-cycle data-memory read controller for the MEM stage.
- Accepts a load request, issues a word-aligned read to data memory with a req/ack handshake, and stalls the pipeline until the memory responds.
- Extracts the addressed byte or halfword from the returned word and sign- or zero-extends it by load type.
- Flags misaligned or illegal loads and memory timeouts.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 16, max REQ cycles waiting for mem_ack before fault; 0 disables the timeout

Ports:
clk  input  1  clock
reset  input  1  reset
ld_valid  input  1  MEM-stage load request; held stable while stall_o=1
ld_addr  input  XLEN  byte address
ld_type  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
flush  input  1  kill the in-flight load
stall_o  output  1  freeze the pipeline
mem_req  output  1  memory read request
mem_addr  output  XLEN  word-aligned address, {ld_addr[XLEN-1:2],2'b00}
mem_rdata  input  XLEN  memory read word
mem_ack  input  1  read data valid, sampled only while mem_req=1
ld_data  output  XLEN  extended load result
ld_done  output  1  one-cycle pulse: ld_data valid
ld_misaligned  output  1  one-cycle pulse: misaligned or illegal ld_type
ld_fault  output  1  one-cycle pulse: timeout

Behaviour:
- Reset is asynchronous, active-high, on clock clk. On reset:
  - state=IDLE;
  - mem_req=0, mem_addr=0, ld_data=0;
  - ld_done=0, ld_misaligned=0, ld_fault=0;
  - timeout counter=0, kill flag=0.
- Reset asserted mid-transaction aborts it immediately; no pulse is produced.
- States are IDLE, REQ, DONE. All outputs except stall_o are registered.
- IDLE:
  - If ld_valid=1 and flush=0, check alignment. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=00. Illegal means ld_type in {011,110,111}.
  - Misaligned or illegal: pulse ld_misaligned next cycle, issue no memory request, stay IDLE.
  - Otherwise: latch addr[1:0] and ld_type, drive mem_addr, set mem_req=1, clear the counter, go to REQ.
  - If ld_valid=1 and flush=1, the request is ignored.
- REQ:
  - mem_req stays 1 and mem_addr stays stable until ack or timeout.
  - On mem_ack=1: capture the extracted mem_rdata into ld_data, drop mem_req, go to DONE.
  - Otherwise the counter increments. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack, drop mem_req, pulse ld_fault, go to IDLE.
  - flush in REQ sets the kill flag. The bus transaction still completes (ack awaited), but ld_data is not updated and no ld_done pulse occurs. A killed load that times out produces no ld_fault.
- DONE:
  - ld_done=1 for exactly one cycle (only if not killed).
  - Return to IDLE. A new ld_valid is not accepted in DONE.
  - ld_data holds its value until the next completed load.
- stall_o = (state==IDLE & ld_valid & ~flush & aligned & legal) | (state==REQ).
  - stall_o is combinational and is 0 in DONE.
  - A misaligned request does not stall.
- Extraction (little-endian, lanes consistent with store byte enables), where w=mem_rdata and a=latched addr[1:0]:
  - Byte: a=00 -> w[7:0], 01 -> w[15:8], 10 -> w[23:16], 11 -> w[31:24].
  - Half: a[1]=0 -> w[15:0], a[1]=1 -> w[31:16].
  - LB/LH sign-extend from bit 7 or bit 15; LBU/LHU zero-extend; LW passes w unchanged.
- Minimum latency: accept at cycle T, mem_req at T+1, ack at T+1, ld_done at T+2.
- mem_ack while mem_req=0 is ignored. A late ack after a timeout is ignored.

Test Plan:
- LW addr 0x80000100, ack on first REQ cycle, rdata 0xDEADBEEF -> mem_addr 0x80000100, ld_done at T+2, ld_data 0xDEADBEEF, stall_o high T..T+1 only.
- LB addr 0x...03, rdata 0x80112233, ack after 3 wait cycles -> ld_data 0xFFFFFF80. Same with LBU -> 0x00000080. mem_addr 0x...00.
- LH addr 0x...02 rdata 0x8001_7FFF -> 0xFFFF8001. LHU addr 0x...00 -> 0x00007FFF.
- LW addr 0x...02, LH addr 0x...01, and ld_type 011 -> ld_misaligned pulse 1 cycle, mem_req never asserted, stall_o 0, ld_data unchanged.
- TIMEOUT=16 with ack never given -> mem_req high for exactly 16 cycles, then ld_fault pulse, state IDLE. An ack applied 2 cycles later has no effect.
- flush in the second REQ cycle, ack in the fourth -> mem_req drops after ack, no ld_done, ld_data unchanged. Async reset during REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/load_unit_if.sv
// Bundles the MEM-stage load request and the data-memory read bus of load_unit.
// The slave modport is the load unit itself; the master modport is the pipeline/memory side.
interface load_unit_if #(
  parameter int XLEN = 32
);
  logic            ld_valid;
  logic [XLEN-1:0] ld_addr;
  logic [2:0]      ld_type;
  logic            flush;
  logic            stall_o;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;
  logic [XLEN-1:0] ld_data;
  logic            ld_done;
  logic            ld_misaligned;
  logic            ld_fault;

  modport slave (
    input  ld_valid, ld_addr, ld_type, flush, mem_rdata, mem_ack,
    output stall_o, mem_req, mem_addr, ld_data, ld_done, ld_misaligned, ld_fault
  );

  modport master (
    output ld_valid, ld_addr, ld_type, flush, mem_rdata, mem_ack,
    input  stall_o, mem_req, mem_addr, ld_data, ld_done, ld_misaligned, ld_fault
  );
endinterface

// File: rtl/load_unit.sv
// Multi-cycle MEM-stage load controller: word-aligned req/ack read, byte/half lane
// extraction with sign/zero extension, misalignment and timeout reporting.
module load_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  load_unit_if.slave  bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            memReq_q, memReq_d;
  logic [XLEN-1:0] memAddr_q, memAddr_d;
  logic [XLEN-1:0] ldData_q, ldData_d;
  logic            done_q, done_d;
  logic            mis_q, mis_d;
  logic            fault_q, fault_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            kill_q, kill_d;
  logic [1:0]      offset_q, offset_d;
  logic [2:0]      type_q, type_d;

  logic            typeOk;
  logic            alignOk;
  logic            accept;
  logic            killNow;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;
  logic [XLEN-1:0] extracted;

  // Request qualification; the size is encoded in funct3[1:0]
  always_comb begin
    typeOk = (bus.ld_type == 3'b000) || (bus.ld_type == 3'b001) || (bus.ld_type == 3'b010) ||
             (bus.ld_type == 3'b100) || (bus.ld_type == 3'b101);
    case (bus.ld_type[1:0])
      2'b00:   alignOk = 1'b1;
      2'b01:   alignOk = ~bus.ld_addr[0];
      2'b10:   alignOk = (bus.ld_addr[1:0] == 2'b00);
      default: alignOk = 1'b0;
    endcase
    accept = (state_q == IDLE) && bus.ld_valid && !bus.flush;
  end

  assign bus.stall_o = (accept && typeOk && alignOk) || (state_q == REQ);

  // Little-endian lane selection from the latched address offset
  always_comb begin
    case (offset_q)
      2'b00:   byteSel = bus.mem_rdata[7:0];
      2'b01:   byteSel = bus.mem_rdata[15:8];
      2'b10:   byteSel = bus.mem_rdata[23:16];
      default: byteSel = bus.mem_rdata[31:24];
    endcase
    halfSel = offset_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (type_q)
      3'b000:  extracted = {{(XLEN-8){byteSel[7]}}, byteSel};
      3'b001:  extracted = {{(XLEN-16){halfSel[15]}}, halfSel};
      3'b100:  extracted = {{(XLEN-8){1'b0}}, byteSel};
      3'b101:  extracted = {{(XLEN-16){1'b0}}, halfSel};
      default: extracted = bus.mem_rdata;
    endcase
  end

  // Next-state logic; a flush in the ack or timeout cycle also suppresses the result
  always_comb begin
    state_d   = state_q;
    memReq_d  = memReq_q;
    memAddr_d = memAddr_q;
    ldData_d  = ldData_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    fault_d   = 1'b0;
    cnt_d     = cnt_q;
    kill_d    = kill_q;
    offset_d  = offset_q;
    type_d    = type_q;
    killNow   = kill_q || bus.flush;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          if (!typeOk || !alignOk) begin
            mis_d = 1'b1;
          end else begin
            offset_d  = bus.ld_addr[1:0];
            type_d    = bus.ld_type;
            memAddr_d = {bus.ld_addr[XLEN-1:2], 2'b00};
            memReq_d  = 1'b1;
            cnt_d     = '0;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        kill_d = killNow;
        if (bus.mem_ack) begin
          memReq_d = 1'b0;
          state_d  = DONE;
          done_d   = !killNow;
          if (!killNow) begin
            ldData_d = extracted;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          memReq_d = 1'b0;
          state_d  = IDLE;
          fault_d  = !killNow;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        memReq_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      ldData_q  <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      kill_q    <= 1'b0;
      offset_q  <= 2'b00;
      type_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
      ldData_q  <= ldData_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      kill_q    <= kill_d;
      offset_q  <= offset_d;
      type_q    <= type_d;
    end
  end

  assign bus.mem_req       = memReq_q;
  assign bus.mem_addr      = memAddr_q;
  assign bus.ld_data       = ldData_q;
  assign bus.ld_done       = done_q;
  assign bus.ld_misaligned = mis_q;
  assign bus.ld_fault      = fault_q;

endmodule

// File: tb/tb_load_unit.sv
// Testbench for load_unit: directed and random loads, expected pulses queued at issue time
// and matched by an independent monitor against an arithmetic reference model.
module tb_load_unit;

  localparam int TIMEOUT = 16;
  localparam int EV_DONE = 1;
  localparam int EV_MIS = 2;
  localparam int EV_FAULT = 4;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } expT;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   ackWait;
  bit   ackNever;
  int   respCnt;
  logic [31:0] lastData;
  expT  expQ[$];

  load_unit_if #(.XLEN(32)) bus ();

  load_unit #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: select the addressed bytes arithmetically and extend by load type
  function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] w);
    longint word;
    longint v;
    int     off;
    word = longint'(w);
    off = int'(a % 4);
    case (t)
      3'b000: begin v = (word >> (8 * off)) % 256; if (v >= 128) v -= 256; end
      3'b001: begin v = (word >> (8 * off)) % 65536; if (v >= 32768) v -= 65536; end
      3'b100: v = (word >> (8 * off)) % 256;
      3'b101: v = (word >> (8 * off)) % 65536;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic bit modelLegal(input logic [2:0] t, input logic [31:0] a);
    int size;
    if (!(t inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
    size = 1 << t[1:0];
    return (a % size) == 0;
  endfunction

  // Memory responder: acks after ackWait REQ cycles unless told never to answer
  always @(negedge clk) begin
    if (reset) begin
      bus.mem_ack = 1'b0;
      respCnt = 0;
    end else if (bus.mem_req) begin
      bus.mem_ack = !ackNever && (respCnt == ackWait);
      respCnt++;
    end else begin
      bus.mem_ack = 1'b0;
      respCnt = 0;
    end
  end

  // Monitor: every result pulse must match the oldest queued expectation
  always @(negedge clk) begin
    int  kind;
    expT e;
    if (!reset && (bus.ld_done || bus.ld_misaligned || bus.ld_fault)) begin
      kind = (bus.ld_done ? EV_DONE : 0) | (bus.ld_misaligned ? EV_MIS : 0) |
             (bus.ld_fault ? EV_FAULT : 0);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_event got kind=%0d expected none at %0t", kind, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("event_kind", 32'(kind), 32'(e.kind));
        checkOutput("ld_data", bus.ld_data, e.data);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                               input int waitCycles, input bit never, input int flushAt);
    bit          legal;
    bit          killed;
    bit          finished;
    int          reqCycles;
    logic [31:0] expData;
    legal = modelLegal(t, a);
    killed = legal && (flushAt >= 0);
    if (!legal) expQ.push_back('{EV_MIS, lastData});
    else if (!killed && never) expQ.push_back('{EV_FAULT, lastData});
    else if (!killed) begin
      expData = modelLoad(t, a, w);
      expQ.push_back('{EV_DONE, expData});
      lastData = expData;
    end

    @(negedge clk);
    ackWait = waitCycles;
    ackNever = never;
    bus.mem_rdata = w;
    bus.ld_type = t;
    bus.ld_addr = a;
    bus.flush = 1'b0;
    bus.ld_valid = 1'b1;
    #1 checkOutput("stall_at_issue", 32'(bus.stall_o), 32'(legal));

    reqCycles = 0;
    finished = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (reqCycles == 0) checkOutput("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        checkOutput("stall_in_req", 32'(bus.stall_o), 32'd1);
        bus.flush = (reqCycles == flushAt);
        if (bus.flush) bus.ld_valid = 1'b0;
        reqCycles++;
      end else begin
        if (legal && !never && !killed) checkOutput("stall_in_done", 32'(bus.stall_o), 32'd0);
        bus.flush = 1'b0;
        bus.ld_valid = 1'b0;
        finished = 1'b1;
      end
    end
    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL load_bound got=unfinished expected=finished at %0t", $time);
      bus.ld_valid = 1'b0;
      bus.flush = 1'b0;
    end
    if (!legal) checkOutput("req_cycles", 32'(reqCycles), 32'd0);
    else if (never) checkOutput("req_cycles", 32'(reqCycles), 32'(TIMEOUT));
    else checkOutput("req_cycles", 32'(reqCycles), 32'(waitCycles + 1));
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  t;
    int          w8;
    int          fa;
    bit          nv;
    total = 0;
    bad = 0;
    lastData = 32'h0;
    ackWait = 0;
    ackNever = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr = 32'h0;
    bus.ld_type = 3'b000;
    bus.flush = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack = 1'b0;
    reset = 1'b1;
    #12;
    checkOutput("reset_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("reset_ld_data", bus.ld_data, 32'h0);
    checkOutput("reset_pulses", {29'd0, bus.ld_done, bus.ld_misaligned, bus.ld_fault}, 32'd0);
    checkOutput("reset_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(3'b010, 32'h8000_0100, 32'hDEAD_BEEF, 0, 1'b0, -1);
    applyStimulus(3'b000, 32'h8000_0203, 32'h8011_2233, 3, 1'b0, -1);
    applyStimulus(3'b100, 32'h8000_0203, 32'h8011_2233, 3, 1'b0, -1);
    applyStimulus(3'b001, 32'h8000_0302, 32'h8001_7FFF, 1, 1'b0, -1);
    applyStimulus(3'b101, 32'h8000_0300, 32'h8001_7FFF, 2, 1'b0, -1);
    applyStimulus(3'b010, 32'h8000_0402, 32'h1234_5678, 0, 1'b0, -1);
    applyStimulus(3'b001, 32'h8000_0401, 32'h1234_5678, 0, 1'b0, -1);
    applyStimulus(3'b011, 32'h8000_0400, 32'h1234_5678, 0, 1'b0, -1);

    // Timeout, then a stray ack two cycles later must be ignored
    applyStimulus(3'b010, 32'h8000_0500, 32'hCAFE_F00D, 0, 1'b1, -1);
    @(negedge clk);
    @(negedge clk);
    #2 bus.mem_ack = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("stray_ack_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    checkOutput("stray_ack_data", bus.ld_data, lastData);

    // Killed load: flush in second REQ cycle, ack in the fourth
    applyStimulus(3'b010, 32'h8000_0600, 32'h5555_AAAA, 3, 1'b0, 1);
    @(negedge clk);
    checkOutput("killed_data", bus.ld_data, lastData);

    // Request with flush in IDLE is ignored
    @(negedge clk);
    bus.ld_type = 3'b010;
    bus.ld_addr = 32'h8000_0700;
    bus.ld_valid = 1'b1;
    bus.flush = 1'b1;
    #1 checkOutput("flush_idle_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    checkOutput("flush_idle_req", 32'(bus.mem_req), 32'd0);
    bus.ld_valid = 1'b0;
    bus.flush = 1'b0;

    for (int i = 0; i < 40; i++) begin
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      w8 = $urandom_range(0, 4);
      nv = ($urandom_range(0, 9) == 0);
      fa = -1;
      if ($urandom_range(0, 5) == 0) begin
        if (nv) fa = $urandom_range(0, 3);
        else if (w8 > 0) fa = $urandom_range(0, w8 - 1);
      end
      applyStimulus(t, a, $urandom, w8, nv, fa);
    end

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    ackNever = 1'b1;
    bus.ld_type = 3'b010;
    bus.ld_addr = 32'h8000_0800;
    bus.ld_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_req", 32'(bus.mem_req), 32'd1);
    bus.ld_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    lastData = 32'h0;
    checkOutput("midreset_mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("midreset_mem_addr", bus.mem_addr, 32'h0);
    checkOutput("midreset_ld_data", bus.ld_data, 32'h0);
    checkOutput("midreset_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(3'b000, 32'h8000_0901, 32'h0000_7F00, 0, 1'b0, -1);

    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
